fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares the single write port of async_fifo_top between NUM_REQ producers in the write clock domain.
- Grants one requester at a time for a burst of up to MAX_BURST words.
- Drives wr_en/din straight into the FIFO and honours the FIFO's full flag.
- Sits between the producer blocks and the FIFO write port, clocked by wclk.

Parameters:
- DATA_WIDTH, 8, width of each data word and of din.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum words written per grant (1..16).

Ports:
- wclk  input  1  write-domain clock; all state changes on posedge.
- wrst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester write request; held high while req_data is valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- full  input  1  FIFO full flag (write domain).
- gnt  output  NUM_REQ  one-hot; gnt[i]=1 means req_data[i] is written at this posedge.
- wr_en  output  1  FIFO write enable.
- din  output  DATA_WIDTH  FIFO write data.
- busy  output  1  high while a burst is owned (state BURST).
- owner  output  3  index of the current or last owner.

Behaviour:
- FSM states: IDLE, BURST. Registers:
  - state
  - owner (3 bits)
  - last_owner (3 bits)
  - cnt (5 bits)
- Reset (async, wrst_n=0), all values immediate:
  - state=IDLE, owner=0, last_owner=NUM_REQ-1, cnt=0.
  - Outputs: wr_en=0, gnt=0, busy=0, din=0, owner=0.
  - Result: requester 0 wins the first arbitration.
- IDLE:
  - wr_en=0, gnt=0.
  - If any req is high at the posedge: owner <= first i with req[i]=1, searching last_owner+1, last_owner+2, ... modulo NUM_REQ. Then cnt <= 0, state <= BURST.
  - Otherwise stay in IDLE.
- BURST:
  - wr_en = req[owner] & ~full (combinational).
  - gnt[owner] = wr_en; every other gnt bit is 0.
  - din = req_data[owner] when wr_en=1, else 0.
  - On each write, cnt <= cnt+1.
- Exit BURST to IDLE (last_owner <= owner, cnt <= 0) at the posedge where either:
  - a write occurs with cnt==MAX_BURST-1 (burst exhausted), or
  - req[owner]=0 (owner released; no write that cycle).
- full=1 in BURST:
  - No write, cnt holds, ownership holds indefinitely. Starvation of others while full is accepted.
  - full is never overridden, so wr_en=1 with full=1 must never occur.
- Latency:
  - req rising while in IDLE: first write at the 2nd posedge after req is sampled (one arbitration cycle).
  - Each burst end costs one IDLE bubble cycle.
  - Peak throughput is MAX_BURST/(MAX_BURST+1) words per cycle.
- Handshake:
  - The requester must keep req and req_data stable until it sees gnt at a posedge.
  - After a gnt it may present the next word or drop req.
  - Dropping req without a gnt is legal (withdraw).
- Fairness: after a burst, the owner has lowest priority at the next arbitration. With all NUM_REQ requesters active, each gets a burst within NUM_REQ arbitrations.
- Requests from non-owners during BURST are ignored until the next IDLE.
- Reset mid-burst: the burst aborts immediately. No partial word is written after wrst_n falls, because wr_en goes to 0 combinationally.
- owner is meaningful only when busy=1, or as the last winner when busy=0.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0]: counts posedges in BURST with req[owner]=1 and full=1. Saturates at 16'hFFFF.
  - Adds input stall_clr (1 bit): synchronous clear, with priority over increment.
  - stall_cnt resets to 0 on wrst_n.
- Undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
- Reset: wrst_n=0 with random req → wr_en=0, gnt=0, busy=0. Release with req=4'b1111, full=0 → owner=0. Words written on 4 consecutive cycles with gnt=4'b0001, then 1 bubble, then owner=1.
- Round-robin: req=4'b1111 held, full=0, data per requester = {id,count} → FIFO write order is 4 words each from 0,1,2,3,0. No requester gets two bursts in a row.
- Early release: req[2] only, drop after 2 grants → exactly 2 writes. Back to IDLE next edge with last_owner=2. A subsequent req=4'b0110 → owner=1.
- Full stall: mid-burst, force full=1 for 5 cycles → wr_en=0, gnt=0, cnt frozen, busy=1. After full=0, the remaining words are written; total per burst stays 4.
- Reset mid-burst: assert wrst_n=0 after 2 of 4 words → wr_en drops the same cycle. After release, arbitration restarts at requester 0.
- With FIFO_WR_ARB_STATS_EN: 5-cycle full stall → stall_cnt=5. stall_clr pulse → 0. Without the macro, the build has no stall_cnt port.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers in the wclk domain.
// Optional stall statistics counter is built when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
`ifdef FIFO_WR_ARB_STATS_EN
    input  logic                          stall_clr,
    output logic [15:0]                   stall_cnt,
`endif
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         din,
    output logic                          busy,
    output logic [2:0]                    owner
);

    localparam int unsigned CNT_W = 5;

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_nxt;
    logic [2:0]         owner_nxt;
    logic [2:0]         last_owner, last_owner_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic               own_req;
    logic [DATA_WIDTH-1:0] own_data;
    logic               arb_hit;
    logic [2:0]         arb_idx;
    logic [2:0]         cand;

    // Select the current owner's request and data word
    always_comb begin
        own_req  = 1'b0;
        own_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner == 3'(i)) begin
                own_req  = req[i];
                own_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin search starting just after the last owner
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 3'((32'(last_owner) + k) % NUM_REQ);
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!arb_hit && cand == 3'(i) && req[i]) begin
                    arb_hit = 1'b1;
                    arb_idx = cand;
                end
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= 3'(NUM_REQ - 1);
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            cnt        <= cnt_nxt;
        end
    end

    // Next state and write-port drive; full always blocks the write
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        wr_en          = 1'b0;
        gnt            = '0;
        din            = '0;
        unique case (state)
            IDLE: begin
                if (arb_hit) begin
                    owner_nxt = arb_idx;
                    cnt_nxt   = '0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                wr_en = own_req & ~full;
                if (wr_en) begin
                    gnt     = NUM_REQ'(1) << owner;
                    din     = own_data;
                    cnt_nxt = cnt + CNT_W'(1);
                end
                if ((wr_en && cnt == CNT_W'(MAX_BURST - 1)) || !own_req) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = owner;
                    cnt_nxt        = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
    // Saturating count of cycles the owner is held off by full
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (state == BURST && own_req && full && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8).
module tb_fifo_wr_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;

    logic            wclk = 1'b0;
    logic            wrst_n;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic            full;
    logic [NR-1:0]   gnt;
    logic            wr_en;
    logic [DW-1:0]   din;
    logic            busy;
    logic [2:0]      owner;
`ifdef FIFO_WR_ARB_STATS_EN
    logic            stall_clr;
    logic [15:0]     stall_cnt;
`endif

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    logic [3:0]  wcnt [NR];

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4)) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req),
        .req_data (req_data),
        .full     (full),
`ifdef FIFO_WR_ARB_STATS_EN
        .stall_clr(stall_clr),
        .stall_cnt(stall_cnt),
`endif
        .gnt      (gnt),
        .wr_en    (wr_en),
        .din      (din),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 wclk = ~wclk;

    // Producers advance to their next word after each grant
    always @(posedge wclk) begin
        for (int i = 0; i < NR; i++)
            if (gnt[i]) wcnt[i] <= wcnt[i] + 4'd1;
    end

    task automatic drive(input logic rst, input logic [NR-1:0] r, input logic f);
        @(negedge wclk);
        wrst_n = rst;
        req    = r;
        full   = f;
        for (int i = 0; i < NR; i++)
            req_data[i*DW +: DW] = {4'(i), wcnt[i]};
        #1;
    endtask

    task automatic check(input string tag, input logic e_wr, input logic [NR-1:0] e_gnt,
                         input logic [DW-1:0] e_din, input logic e_busy, input logic [2:0] e_own);
        logic [16:0] obs;
        logic [16:0] expv;
        obs  = {wr_en, gnt, din, busy, owner};
        expv = {e_wr, e_gnt, e_din, e_busy, e_own};
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: wr_en/gnt/din/busy/owner observed %b/%b/%h/%b/%0d expected %b/%b/%h/%b/%0d",
                   tag, wr_en, gnt, din, busy, owner, e_wr, e_gnt, e_din, e_busy, e_own);
        end
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic check_stall(input string tag, input logic [15:0] e_cnt);
        vectors++;
        assert (stall_cnt === e_cnt) else begin
            errors++;
            $error("FAIL %s: stall_cnt observed %0d expected %0d", tag, stall_cnt, e_cnt);
        end
    endtask
`endif

    initial begin
        logic [2:0] id;
        int         base;
        for (int i = 0; i < NR; i++) wcnt[i] = 4'd0;
        wrst_n   = 1'b0;
        req      = '0;
        req_data = '0;
        full     = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
        stall_clr = 1'b0;
`endif

        // Reset with arbitrary requests present
        drive(1'b0, 4'b1010, 1'b0);
        check("reset", 1'b0, 4'b0000, 8'h00, 1'b0, 3'd0);
`ifdef FIFO_WR_ARB_STATS_EN
        check_stall("stall_reset", 16'd0);
`endif
        drive(1'b1, 4'b1111, 1'b0);
        check("release_idle", 1'b0, 4'b0000, 8'h00, 1'b0, 3'd0);

        // All requesters active: bursts of 4 in order 0,1,2,3,0 with one bubble each
        for (int b = 0; b < 5; b++) begin
            id   = 3'(b % 4);
            base = (b == 4) ? 4 : 0;
            for (int w = 0; w < 4; w++) begin
                drive(1'b1, 4'b1111, 1'b0);
                check("rr_word", 1'b1, 4'(1 << id), {4'(id), 4'(base + w)}, 1'b1, id);
            end
            drive(1'b1, (b == 4) ? 4'b0100 : 4'b1111, 1'b0);
            check("rr_bubble", 1'b0, 4'b0000, 8'h00, 1'b0, id);
        end

        // Requester 2 alone, releases after two words
        drive(1'b1, 4'b0100, 1'b0);
        check("early_w0", 1'b1, 4'b0100, 8'h24, 1'b1, 3'd2);
        drive(1'b1, 4'b0100, 1'b0);
        check("early_w1", 1'b1, 4'b0100, 8'h25, 1'b1, 3'd2);
        drive(1'b1, 4'b0000, 1'b0);
        check("early_drop", 1'b0, 4'b0000, 8'h00, 1'b1, 3'd2);
        drive(1'b1, 4'b0110, 1'b0);
        check("early_idle", 1'b0, 4'b0000, 8'h00, 1'b0, 3'd2);

        // Next arbitration after owner 2 goes to requester 1
        drive(1'b1, 4'b0110, 1'b0);
        check("after_early", 1'b1, 4'b0010, 8'h14, 1'b1, 3'd1);
        drive(1'b1, 4'b0110, 1'b0);
        check("stall_pre", 1'b1, 4'b0010, 8'h15, 1'b1, 3'd1);

        // Five full cycles mid-burst: no write, ownership held
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, 4'b0110, 1'b1);
            check("stall_full", 1'b0, 4'b0000, 8'h00, 1'b1, 3'd1);
        end
        drive(1'b1, 4'b0110, 1'b0);
        check("stall_resume0", 1'b1, 4'b0010, 8'h16, 1'b1, 3'd1);
`ifdef FIFO_WR_ARB_STATS_EN
        check_stall("stall_count", 16'd5);
        stall_clr = 1'b1;
`endif
        drive(1'b1, 4'b0110, 1'b0);
        check("stall_resume1", 1'b1, 4'b0010, 8'h17, 1'b1, 3'd1);
`ifdef FIFO_WR_ARB_STATS_EN
        stall_clr = 1'b0;
`endif
        drive(1'b1, 4'b1111, 1'b0);
        check("stall_bubble", 1'b0, 4'b0000, 8'h00, 1'b0, 3'd1);
`ifdef FIFO_WR_ARB_STATS_EN
        check_stall("stall_clear", 16'd0);
`endif

        // Reset after two words of requester 2's burst
        drive(1'b1, 4'b1111, 1'b0);
        check("mid_w0", 1'b1, 4'b0100, 8'h26, 1'b1, 3'd2);
        drive(1'b1, 4'b1111, 1'b0);
        check("mid_w1", 1'b1, 4'b0100, 8'h27, 1'b1, 3'd2);
        drive(1'b0, 4'b1111, 1'b0);
        check("mid_reset", 1'b0, 4'b0000, 8'h00, 1'b0, 3'd0);
        drive(1'b0, 4'b1111, 1'b0);
        check("mid_reset_hold", 1'b0, 4'b0000, 8'h00, 1'b0, 3'd0);
        drive(1'b1, 4'b1111, 1'b0);
        check("mid_release", 1'b0, 4'b0000, 8'h00, 1'b0, 3'd0);
        drive(1'b1, 4'b1111, 1'b0);
        check("mid_restart", 1'b1, 4'b0001, 8'h08, 1'b1, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
